// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl - time-multiplexed 7-segment scan controller.
//
// Scans NUM_DIGITS common-driven digits one slot at a time. Each slot lasts SCAN_DIV clocks.
// The first BLANK_CYC clocks of every slot are dead time with com/seg forced low, which stops
// ghosting when the digit changes. Display words arrive over a valid/ready handshake into a
// one-entry pending buffer. That buffer is copied into the shadow register only at the frame
// wrap, so a frame never shows a mix of old and new digits.
//
// Build option: define LZ_BLANK_EN to enable leading-zero suppression. A zero digit shows no
// segments when all higher digits are suppressed zeros too; digit 0 is never suppressed, and
// dp and com are unaffected.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   en         scan enable; low blanks the display and freezes div/idx
//   data_in    4-bit code per digit, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in      decimal point per digit, captured with data_in
//   data_valid data_in/dp_in valid
//   data_ready pending buffer empty, a word can be accepted
//   com        one-hot digit enables, active-high (registered)
//   seg        segments a..g in bits 0..6, dp in bit 7, active-high (registered)
//   frame_done one-cycle pulse on the cycle after each frame wrap (registered)
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [NUM_DIGITS-1:0]   com,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam int unsigned DivW = $clog2(SCAN_DIV);

    localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);
    localparam logic [DivW-1:0] BlankEnd = DivW'(BLANK_CYC);

    typedef enum logic {StBlank, StDrive} state_e;

    state_e                  state_q, state_d;
    logic [DivW-1:0]         div_q, div_d, div_cur;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    rearm_q, rearm_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_full_q, pend_full_d;
    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   com_q, com_d;
    logic [7:0]              seg_q, seg_d;
    logic                    frame_done_q, frame_done_d;
    logic                    frame_wrap;
    logic [NUM_DIGITS-1:0]   sup;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_sup;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // While en is low div holds its value, but the slot must restart from a full blank when
    // scanning resumes; rearm_q makes the divider read as zero on that first enabled cycle.
    assign div_cur    = rearm_q ? '0 : div_q;
    assign frame_wrap = en && (div_cur == DivLast) && (idx_q == IdxLast);

    always_comb begin
        div_d   = div_q;
        idx_d   = idx_q;
        rearm_d = rearm_q;
        if (!en) begin
            rearm_d = 1'b1;
        end else begin
            rearm_d = 1'b0;
            if (div_cur == DivLast) begin
                div_d = '0;
                idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
            end else begin
                div_d = div_cur + DivW'(1);
            end
        end
    end

    // FSM: state register. state_q always matches the phase of the effective divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBlank;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A disabled cycle leads to a restart at div 0, which is blank.
    always_comb begin
        state_d = StBlank;
        if (en && (div_d >= BlankEnd)) begin
            state_d = StDrive;
        end
    end

`ifdef LZ_BLANK_EN
    always_comb begin
        logic run;
        run = 1'b1;
        sup = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run    = run && (shadow_data_q[4*i +: 4] == 4'h0);
            sup[i] = run;
        end
    end
`else
    assign sup = '0;
`endif

    always_comb begin
        cur_code = 4'h0;
        cur_dp   = 1'b0;
        cur_sup  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_code = shadow_data_q[4*i +: 4];
                cur_dp   = shadow_dp_q[i];
                cur_sup  = sup[i];
            end
        end
    end

    // FSM: outputs, registered one cycle behind div/idx.
    always_comb begin
        com_d        = '0;
        seg_d        = '0;
        frame_done_d = frame_wrap;
        if (en && (state_q == StDrive)) begin
            com_d = NUM_DIGITS'(1) << idx_q;
            seg_d = {cur_dp, cur_sup ? 7'h00 : decode(cur_code)};
        end
    end

    // Pending buffer and shadow. Acceptance requires an empty buffer, so it can never collide
    // with the wrap-time transfer of a full one.
    always_comb begin
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_full_d   = pend_full_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (frame_wrap && pend_full_q) begin
            shadow_data_d = pend_data_q;
            shadow_dp_d   = pend_dp_q;
            pend_full_d   = 1'b0;
        end
        if (data_valid && !pend_full_q) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            idx_q         <= '0;
            rearm_q       <= 1'b0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_full_q   <= 1'b0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            com_q         <= '0;
            seg_q         <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            div_q         <= div_d;
            idx_q         <= idx_d;
            rearm_q       <= rearm_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_full_q   <= pend_full_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            com_q         <= com_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign data_ready = !pend_full_q;
    assign com        = com_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with NUM_DIGITS=3, SCAN_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

    localparam int ND = 3;
    localparam int SD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] data_in;
    logic [2:0]  dp_in;
    logic        data_valid;
    logic        data_ready;
    logic [2:0]  com;
    logic [7:0]  seg;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .com        (com),
        .seg        (seg),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries: {frame_done, com[2:0], seg[7:0]}
    logic [11:0] exp_q[$];

    // Reference model state
    int          m_div;
    int          m_idx;
    logic        m_prev_en;
    logic [11:0] m_shadow;
    logic [2:0]  m_sdp;
    logic [11:0] m_pend;
    logic [2:0]  m_pdp;
    logic        m_full;

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[c];
    endfunction

    // Segment pattern a..g that digit k of the shadow word should light.
    function automatic logic [6:0] shown(input int k);
        logic [3:0] c;
        c = m_shadow[4*k +: 4];
`ifdef LZ_BLANK_EN
        if (k != 0) begin
            logic all_zero;
            all_zero = 1'b1;
            for (int j = k; j < ND; j++) begin
                if (m_shadow[4*j +: 4] != 4'h0) all_zero = 1'b0;
            end
            if (all_zero) return 7'h00;
        end
`endif
        return seg_of(c);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div     = 0;
        m_idx     = 0;
        m_prev_en = 1'b1;
        m_shadow  = '0;
        m_sdp     = '0;
        m_pend    = '0;
        m_pdp     = '0;
        m_full    = 1'b0;
    endtask

    // One clock: predict the registered outputs, advance the model, then compare.
    task automatic tick();
        int          d;
        logic [2:0]  ecom;
        logic [7:0]  eseg;
        logic        efd;
        logic        acc;
        logic [11:0] e;
        d    = (en && !m_prev_en) ? 0 : m_div;
        ecom = '0;
        eseg = '0;
        if (en && d >= BC) begin
            ecom = 3'(1 << m_idx);
            eseg = {m_sdp[m_idx], shown(m_idx)};
        end
        efd = en && (d == SD - 1) && (m_idx == ND - 1);
        exp_q.push_back({efd, ecom, eseg});

        acc = data_valid && !m_full;
        if (en) begin
            if (d == SD - 1) begin
                m_div = 0;
                m_idx = (m_idx + 1) % ND;
            end else begin
                m_div = d + 1;
            end
        end
        if (efd && m_full) begin
            m_shadow = m_pend;
            m_sdp    = m_pdp;
            m_full   = 1'b0;
        end
        if (acc) begin
            m_pend = data_in;
            m_pdp  = dp_in;
            m_full = 1'b1;
        end
        m_prev_en = en;

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("com", 32'(com), 32'(e[10:8]));
        check("seg", 32'(seg), 32'(e[7:0]));
        check("frame_done", 32'(frame_done), 32'(e[11]));
        check("data_ready", 32'(data_ready), 32'(!m_full));
    endtask

    // Advance until the next tick would be the frame wrap cycle.
    task automatic wait_wrap();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (en && m_prev_en && m_div == SD - 1 && m_idx == ND - 1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("wrap_reached", 32'(found), 32'd1);
    endtask

    task automatic wait_slot(input int idx, input int div);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_idx == idx && m_div == div && m_prev_en) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("slot_reached", 32'(found), 32'd1);
    endtask

    task automatic send(input logic [11:0] w, input logic [2:0] dp);
        data_in    = w;
        dp_in      = dp;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        dp_in      = '0;
        model_reset();

        #12;
        check("rst_com", 32'(com), 32'd0);
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle scanning of the all-zero word over more than one frame.
        repeat (30) tick();

        // Mid-frame word; valid stays high with different data while the buffer is full.
        wait_slot(1, 3);
        data_in    = 12'h1A9;
        dp_in      = 3'b010;
        data_valid = 1'b1;
        tick();
        data_in = 12'h222;
        dp_in   = 3'b111;
        tick();
        tick();
        data_valid = 1'b0;
        repeat (50) tick();

        // Word offered exactly in the wrap cycle is held back one whole frame.
        wait_wrap();
        send(12'h555, 3'b000);
        repeat (55) tick();

        // Scan gap during DRIVE of digit 1; a word is accepted while disabled.
        wait_slot(1, 4);
        en = 1'b0;
        tick();
        send(12'h321, 3'b100);
        repeat (3) tick();
        en = 1'b1;
        repeat (40) tick();

        // Asynchronous reset mid-slot with a word pending.
        wait_wrap();
        tick();
        send(12'h777, 3'b001);
        wait_slot(0, 4);
        #3;
        rst = 1'b1;
        #1;
        check("arst_com", 32'(com), 32'd0);
        check("arst_seg", 32'(seg), 32'd0);
        check("arst_data_ready", 32'(data_ready), 32'd1);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        check("arst_hold_com", 32'(com), 32'd0);
        rst = 1'b0;
        repeat (30) tick();

        // Leading-zero patterns (suppressed only when LZ_BLANK_EN is defined).
        send(12'h007, 3'b000);
        repeat (50) tick();
        send(12'h000, 3'b000);
        repeat (50) tick();
        send(12'h090, 3'b100);
        repeat (50) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
